// File: rtl/spi_pkg.sv
// Shared SPI target definitions: frame width and the frame-level FSM state type.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_st_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pad input; reset value is a parameter
// so idle-high signals such as cs_n come out of reset deselected.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target front-end: oversampled sclk/cs_n/mosi, MSB-first byte deserialiser
// and MISO serialiser. Define SPI_PERIPH_FRAME_ERR_EN to add the frame_err output.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BYTE_W      = SPI_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              new_data,
  output logic [BYTE_W-1:0] rx_data,
  input  logic [BYTE_W-1:0] tx_data
`ifdef SPI_PERIPH_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W  = $clog2(BYTE_W);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BYTE_W - 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;
  logic sclk_rise, sclk_fall, cs_fall;
  logic [WARM_W-1:0] warm_cnt;
  logic settled;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (sclk), .q (sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk (clk), .rst (rst), .d (cs_n), .q (cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (mosi), .q (mosi_s)
  );

  // cs_n_d only tracks cs_n_s once the chains hold real pad samples, so a select held
  // low through reset never looks like a fresh high->low transition.
  assign settled = (warm_cnt == WARM_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt <= '0;
      sclk_d   <= 1'b0;
      cs_n_d   <= 1'b0;
    end else begin
      if (!settled) warm_cnt <= warm_cnt + WARM_W'(1);
      sclk_d <= sclk_s;
      if (settled) cs_n_d <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_n_d & ~cs_n_s;

  spi_st_t state_q, state_d;
  logic enter, leave, shift_in, shift_out;

  always_ff @(posedge clk) begin
    if (rst) state_q <= SPI_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPI_IDLE:   if (cs_fall) state_d = SPI_ACTIVE;
      SPI_ACTIVE: if (cs_n_s)  state_d = SPI_IDLE;
      default:    state_d = SPI_IDLE;
    endcase
  end

  // Deselect takes priority: an sclk edge seen in the same cycle cs_n_s is high is dropped.
  always_comb begin
    enter     = 1'b0;
    leave     = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    case (state_q)
      SPI_IDLE: enter = cs_fall;
      SPI_ACTIVE: begin
        if (cs_n_s) begin
          leave = 1'b1;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: ;
    endcase
  end

  logic [BYTE_W-2:0] rx_sr;
  logic [BYTE_W-1:0] tx_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              reload;

  // Receive handshake: new_data is a one-cycle strobe marking rx_data as a fresh byte;
  // there is no ready, the controller must take it in that cycle (rx_data also holds).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr    <= '0;
      tx_sr    <= '0;
      bit_cnt  <= '0;
      reload   <= 1'b0;
      rx_data  <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= 1'b0;
      if (enter) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
        reload  <= 1'b0;
      end else if (leave) begin
        bit_cnt <= '0;
        reload  <= 1'b0;
      end else begin
        if (shift_in) begin
          rx_sr <= {rx_sr[BYTE_W-3:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= {rx_sr, mosi_s};
            new_data <= 1'b1;
            bit_cnt  <= '0;
            reload   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        // The reload falls on the last bit's trailing edge, long after new_data,
        // so the controller's response byte is already registered on tx_data.
        if (shift_out) begin
          if (reload) begin
            tx_sr  <= tx_data;
            reload <= 1'b0;
          end else begin
            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign miso_oe = (state_q == SPI_ACTIVE);
  assign miso    = miso_oe & tx_sr[BYTE_W-1];

`ifdef SPI_PERIPH_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= leave && (bit_cnt != '0);
  end
`else
  // Without the status output a partial byte at deselect is simply dropped.
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: reset, two-byte frame, abort, back-to-back,
// minimum clock ratio with random bytes, and reset mid-frame.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe, new_data;
  logic [7:0] rx_data, tx_data;
`ifdef SPI_PERIPH_FRAME_ERR_EN
  logic       frame_err;
`endif

  int total = 0;
  int bad   = 0;
  int nd_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];

  spi_peripheral dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .new_data (new_data),
    .rx_data  (rx_data),
    .tx_data  (tx_data)
`ifdef SPI_PERIPH_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every new_data pulse pops one expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && new_data === 1'b1) begin
      nd_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
      end
      if (exp_q.size() != 0) check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
`ifdef SPI_PERIPH_FRAME_ERR_EN
    if (rst === 1'b0 && frame_err === 1'b1) fe_cnt++;
`endif
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Mode-0 controller: mosi changes on the falling edge, miso captured at the rising edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                          input logic [7:0] tx_next, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(half);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      if (i == 0) tx_data = tx_next;
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi, mo, cur_tx, nxt_tx;
    int nd0, fe0;
    logic [7:0] b2b [3];
    logic [7:0] b2b_tx [3];
    b2b    = '{8'h03, 8'h5A, 8'hC3};
    b2b_tx = '{8'h3C, 8'h96, 8'h69};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h00;
    wait_clk(4);
    check("rst_miso",     {31'h0, miso},     32'h0);
    check("rst_miso_oe",  {31'h0, miso_oe},  32'h0);
    check("rst_new_data", {31'h0, new_data}, 32'h0);
    check("rst_rx_data",  {24'h0, rx_data},  32'h0);
`ifdef SPI_PERIPH_FRAME_ERR_EN
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
`endif

    // 1: select held low through reset must not open a frame
    cs_n = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    nd0 = nd_cnt;
    spi_bits(8'hFF, 8, 8, 8'h00, mi);
    check("t1_miso_oe", {31'h0, miso_oe}, 32'h0);
    wait_clk(6);
    check("t1_no_pulse", nd_cnt, nd0);
    cs_n = 1'b1;
    wait_clk(8);

    // 2: two-byte frame
    tx_data = 8'h07;
    nd0 = nd_cnt;
    cs_low();
    check("t2_miso_oe", {31'h0, miso_oe}, 32'h1);
    exp_q.push_back(8'h80);
    spi_bits(8'h80, 8, 8, 8'hA5, mi);
    check("t2_miso_b0", {24'h0, mi}, 32'h07);
    exp_q.push_back(8'h00);
    spi_bits(8'h00, 8, 8, 8'h00, mi);
    check("t2_miso_b1", {24'h0, mi}, 32'hA5);
    cs_high();
    check("t2_pulses", nd_cnt - nd0, 2);
    check("t2_rx_hold", {24'h0, rx_data}, 32'h00);
    check("t2_oe_off", {31'h0, miso_oe}, 32'h0);

    // 3: abort after 5 bits
    nd0 = nd_cnt;
    fe0 = fe_cnt;
    cs_low();
    spi_bits(8'hFF, 5, 8, 8'h00, mi);
    cs_high();
    check("t3_no_pulse", nd_cnt, nd0);
    check("t3_rx_kept", {24'h0, rx_data}, 32'h00);
`ifdef SPI_PERIPH_FRAME_ERR_EN
    check("t3_frame_err", fe_cnt - fe0, 1);
`endif

    // 4: back-to-back bytes
    nd0 = nd_cnt;
    tx_data = b2b_tx[0];
    cs_low();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(b2b[k]);
      spi_bits(b2b[k], 8, 8, (k < 2) ? b2b_tx[k+1] : 8'h00, mi);
      check("t4_miso", {24'h0, mi}, {24'h0, b2b_tx[k]});
    end
    cs_high();
    check("t4_pulses", nd_cnt - nd0, 3);

    // 5: minimum ratio, random bytes
    cur_tx = 8'($urandom_range(0, 255));
    tx_data = cur_tx;
    cs_low();
    for (int k = 0; k < 64; k++) begin
      mo = 8'($urandom_range(0, 255));
      nxt_tx = 8'($urandom_range(0, 255));
      exp_q.push_back(mo);
      spi_bits(mo, 8, 4, nxt_tx, mi);
      check("t5_miso", {24'h0, mi}, {24'h0, cur_tx});
      cur_tx = nxt_tx;
    end
    cs_high();
    check("t5_rx_last", {24'h0, rx_data}, {24'h0, mo});

    // 6: reset mid-byte, then a clean frame
    cs_low();
    spi_bits(8'hAA, 4, 8, 8'h00, mi);
    rst = 1'b1;
    wait_clk(3);
    check("t6_rst_rx", {24'h0, rx_data}, 32'h0);
    check("t6_rst_oe", {31'h0, miso_oe}, 32'h0);
    rst = 1'b0;
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    nd0 = nd_cnt;
    cs_low();
    exp_q.push_back(8'h81);
    spi_bits(8'h81, 8, 8, 8'h00, mi);
    cs_high();
    check("t6_pulses", nd_cnt - nd0, 1);
    check("t6_rx", {24'h0, rx_data}, 32'h81);

    check("sb_empty", exp_q.size(), 0);
`ifdef SPI_PERIPH_FRAME_ERR_EN
    check("fe_total", fe_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
